branch_pc_unit: RTL and testbench
=================================

// Module: branch_pc_unit
// PURPOSE
//  Branch sequencer and program counter for the CPU datapath. On a branch instruction it pulses
//  con_in to the CON flip-flop logic and reads back con_out one cycle later. If taken, it adds
//  the sign-extended C field to the PC. Otherwise the PC is left as is. Outside branches it
//  performs normal PC increment/jump loads for the fetch sequence.
// PARAMETERS
//  PC_W      32   PC width; all PC arithmetic is modulo 2**PC_W
//  OFF_W     19   branch offset width, taken from ir[OFF_W-1:0]
//  RESET_PC  0    PC value loaded on clr
//  CNT_W     16   width of statistics counters (only when BRANCH_STATS_EN)
// PORTS
//  clk            in   1      system clock, all state on posedge
//  clr            in   1      synchronous active-high reset
//  start          in   1      decoded branch instruction; accepted only in IDLE
//  ir             in   32     instruction register; ir[OFF_W-1:0] = signed offset, held stable start..done
//  con_out        in   1      registered condition from CON flip-flop logic
//  pc_inc_en      in   1      PC <= PC + 1 (fetch), honoured only in IDLE
//  pc_load_en     in   1      PC <= pc_load_val (jump), honoured only in IDLE
//  pc_load_val    in   PC_W   jump target
//  con_in         out  1      enable to CON flip-flop; high exactly during EVAL
//  busy           out  1      state != IDLE
//  done           out  1      one-cycle pulse in DONE state
//  taken          out  1      registered branch outcome, valid from DONE until next start
//  pc_out         out  PC_W   current PC register
//  taken_cnt      out  CNT_W  taken branches (BRANCH_STATS_EN only)
//  not_taken_cnt  out  CNT_W  not-taken branches (BRANCH_STATS_EN only)
// BEHAVIOUR
//  Reset (clr=1 at posedge; overrides everything, including mid-branch):
//   state=IDLE, pc_out=RESET_PC, taken=0, counters=0.
//   con_in/busy/done are therefore 0 in the cycle after reset.
//  FSM: IDLE -start-> EVAL -> RESOLVE -> DONE -> IDLE (unconditional advances after start).
//   EVAL: con_in=1; the CON FF samples at the closing edge.
//   RESOLVE: con_out is valid. At the closing edge: taken<=con_out.
//    If con_out=1, pc<=pc+sext(ir[OFF_W-1:0]); otherwise pc is unchanged.
//   DONE: done=1, busy=1.
//  Latency: start sampled at edge E0; PC/taken update at E2; done high during cycle E2..E3.
//   Back-to-back start is accepted at E3 (first IDLE cycle), giving one branch per 4 cycles.
//  IDLE PC priority: pc_load_en > pc_inc_en. start in the same cycle is still accepted.
//   The branch offset is then applied to the already-updated PC.
//  While busy: start, pc_inc_en and pc_load_en are ignored (no queuing).
//  Arithmetic: offset is sign-extended OFF_W->PC_W. Adds wrap silently:
//   0xFFFFFFFF+1=0; 0x00000002 + sext(0x7FFFE) = 0x00000000.
//  con_out is ignored in every state except RESOLVE.
// CONFIGURATION
//  BRANCH_STATS_EN defined: taken_cnt/not_taken_cnt increment at the RESOLVE edge per outcome.
//   They saturate at 2**CNT_W-1 and are cleared by clr.
//  Not defined: counters are absent, ports are driven to 0, and no stats flops are synthesised.
// STRUCTURE
//  Package branch_pkg: state enum {IDLE,EVAL,RESOLVE,DONE}, OFF_W default, sext_off() function.
//  Sub-module pc_reg: PC register with clr/load/inc/add-offset controls and a one-hot select
//   from the FSM. The top level holds the FSM, taken flop and stats counters.
// TESTING
//  1 clr, then pc_inc_en x3 -> pc_out=3; busy=0, con_in=0, done=0 throughout.
//  2 pc=0x100, ir[18:0]=0x00010, start, con_out=1 in RESOLVE -> con_in high 1 cycle;
//    done at E2; pc=0x110, taken=1.
//  3 same as 2 with con_out=0 -> pc stays 0x100, taken=0, done after 3 cycles.
//  4 pc=0x10, offset=0x7FFF0 (-16), taken -> pc=0x0. Then pc=0xFFFFFFFF, pc_inc_en -> pc=0.
//  5 pc_inc_en/pc_load_en/start asserted during EVAL..DONE -> ignored.
//    clr in RESOLVE -> IDLE, pc=RESET_PC, no done pulse.
//  6 BRANCH_STATS_EN, CNT_W=2: 5 taken branches -> taken_cnt=3 (saturated), not_taken_cnt=0.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch sequencer / program counter slice.
package branch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    RESOLVE,
    DONE
  } state_t;

  // One-hot PC operation select driven by the sequencer into pc_reg.
  typedef enum logic [2:0] {
    PC_HOLD = 3'b000,
    PC_INC  = 3'b001,
    PC_LOAD = 3'b010,
    PC_ADD  = 3'b100
  } pc_op_t;

  localparam int OFF_W_DEF = 19;
  localparam int SEXT_W    = 64;

  // Sign-extend ir[off_w-1:0] to SEXT_W bits; callers slice down to their PC width.
  function automatic logic [SEXT_W-1:0] sext_off(input logic [31:0] ir_val,
                                                 input int unsigned off_w);
    logic [SEXT_W-1:0] res;
    logic              sign;
    sign = ir_val[5'(off_w - 1)];
    for (int i = 0; i < SEXT_W; i++) begin
      res[i] = (i < int'(off_w)) ? ir_val[i[4:0]] : sign;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_pc_unit_pc_reg.sv
// Program counter register: clear, increment, jump load or add a branch offset.
module pc_reg
  import branch_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            clr,
  input  pc_op_t          op,
  input  logic [PC_W-1:0] load_val,
  input  logic [PC_W-1:0] offset,
  output logic [PC_W-1:0] pc
);

  // All arithmetic wraps modulo 2**PC_W by construction of the adder width.
  always_ff @(posedge clk) begin
    if (clr) begin
      pc <= RESET_PC;
    end else begin
      case (op)
        PC_INC:  pc <= pc + PC_W'(1);
        PC_LOAD: pc <= load_val;
        PC_ADD:  pc <= pc + offset;
        default: pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Branch sequencer + PC top level. Define BRANCH_STATS_EN to build the saturating
// taken/not-taken statistics counters; otherwise those ports are tied to zero.
module branch_pc_unit
  import branch_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              OFF_W    = OFF_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [31:0]      ir,
  input  logic             con_out,
  input  logic             pc_inc_en,
  input  logic             pc_load_en,
  input  logic [PC_W-1:0]  pc_load_val,
  output logic             con_in,
  output logic             busy,
  output logic             done,
  output logic             taken,
  output logic [PC_W-1:0]  pc_out,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] not_taken_cnt
);

  state_t              state;
  pc_op_t              pc_op;
  logic [SEXT_W-1:0]   offset_ext;
  logic [PC_W-1:0]     offset;

  assign offset_ext = sext_off(ir, OFF_W);
  assign offset     = offset_ext[PC_W-1:0];

  generate
    if (PC_W < SEXT_W) begin : g_offset_hi
      logic offset_unused;
      assign offset_unused = ^offset_ext[SEXT_W-1:PC_W];
    end
  endgenerate

  // Fetch loads/increments only happen in IDLE; the branch add only at the RESOLVE edge.
  always_comb begin
    pc_op = PC_HOLD;
    case (state)
      IDLE: begin
        if (pc_load_en)     pc_op = PC_LOAD;
        else if (pc_inc_en) pc_op = PC_INC;
      end
      RESOLVE: if (con_out) pc_op = PC_ADD;
      default: pc_op = PC_HOLD;
    endcase
  end

  pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .clr      (clr),
    .op       (pc_op),
    .load_val (pc_load_val),
    .offset   (offset),
    .pc       (pc_out)
  );

  // Outputs are registered alongside the state so they line up with it exactly.
  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= IDLE;
      con_in <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      taken  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= EVAL;
            con_in <= 1'b1;
            busy   <= 1'b1;
          end
        end
        EVAL: begin
          state  <= RESOLVE;
          con_in <= 1'b0;
        end
        RESOLVE: begin
          state <= DONE;
          done  <= 1'b1;
          taken <= con_out;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (clr) begin
      taken_cnt     <= '0;
      not_taken_cnt <= '0;
    end else if (state == RESOLVE) begin
      if (con_out) begin
        if (taken_cnt != '1) taken_cnt <= taken_cnt + CNT_W'(1);
      end else begin
        if (not_taken_cnt != '1) not_taken_cnt <= not_taken_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign taken_cnt     = '0;
  assign not_taken_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed self-checking bench for branch_pc_unit (counters checked in both builds).
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [31:0] ir = '0;
  logic        con_out = 1'b0;
  logic        pc_inc_en = 1'b0;
  logic        pc_load_en = 1'b0;
  logic [31:0] pc_load_val = '0;
  logic        con_in, busy, done, taken;
  logic [31:0] pc_out;
  logic [1:0]  taken_cnt, not_taken_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_pc_unit #(.CNT_W(2)) dut (
    .clk           (clk),
    .clr           (clr),
    .start         (start),
    .ir            (ir),
    .con_out       (con_out),
    .pc_inc_en     (pc_inc_en),
    .pc_load_en    (pc_load_en),
    .pc_load_val   (pc_load_val),
    .con_in        (con_in),
    .busy          (busy),
    .done          (done),
    .taken         (taken),
    .pc_out        (pc_out),
    .taken_cnt     (taken_cnt),
    .not_taken_cnt (not_taken_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pc(input logic [31:0] v);
    pc_load_val = v;
    pc_load_en  = 1'b1;
    step();
    pc_load_en  = 1'b0;
  endtask

  task automatic applyStimulus(input logic [18:0] off, input logic cond);
    ir    = {13'd0, off};
    start = 1'b1;
    step();
    start   = 1'b0;
    step();
    con_out = cond;
    step();
    con_out = 1'b0;
    step();
  endtask

  task automatic test_reset();
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++; if (pc_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc got %h exp %h", pc_out, 32'h0); end
    checks++; if ({busy, con_in, done, taken} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags got %b exp 0000", {busy, con_in, done, taken}); end
    checks++; if ({taken_cnt, not_taken_cnt} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_cnt got %b exp 0000", {taken_cnt, not_taken_cnt}); end
  endtask

  task automatic test_increment();
    pc_inc_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (pc_out !== 32'(i)) begin errors++; $display("[TB] FAIL inc_pc got %h exp %h", pc_out, 32'(i)); end
      checks++; if ({busy, con_in, done} !== 3'b000) begin errors++; $display("[TB] FAIL inc_flags got %b exp 000", {busy, con_in, done}); end
    end
    pc_inc_en = 1'b0;
  endtask

  task automatic test_branch_taken();
    load_pc(32'h100);
    ir    = 32'h0000_0010;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if ({con_in, busy, done} !== 3'b110) begin errors++; $display("[TB] FAIL eval_flags got %b exp 110", {con_in, busy, done}); end
    step();
    con_out = 1'b1;
    checks++; if ({con_in, busy, done} !== 3'b010) begin errors++; $display("[TB] FAIL resolve_flags got %b exp 010", {con_in, busy, done}); end
    checks++; if (pc_out !== 32'h100) begin errors++; $display("[TB] FAIL resolve_pc got %h exp %h", pc_out, 32'h100); end
    step();
    con_out = 1'b0;
    checks++; if ({con_in, busy, done} !== 3'b011) begin errors++; $display("[TB] FAIL done_flags got %b exp 011", {con_in, busy, done}); end
    checks++; if (pc_out !== 32'h110) begin errors++; $display("[TB] FAIL taken_pc got %h exp %h", pc_out, 32'h110); end
    checks++; if (taken !== 1'b1) begin errors++; $display("[TB] FAIL taken_flag got %b exp 1", taken); end
    step();
    checks++; if ({busy, done, taken} !== 3'b001) begin errors++; $display("[TB] FAIL idle_after got %b exp 001", {busy, done, taken}); end
  endtask

  task automatic test_branch_not_taken();
    load_pc(32'h100);
    ir    = 32'h0000_0010;
    start = 1'b1;
    step();
    start   = 1'b0;
    con_out = 1'b1;
    step();
    con_out = 1'b0;
    step();
    con_out = 1'b1;
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL nt_done got %b exp 1", done); end
    checks++; if (pc_out !== 32'h100) begin errors++; $display("[TB] FAIL nt_pc got %h exp %h", pc_out, 32'h100); end
    checks++; if (taken !== 1'b0) begin errors++; $display("[TB] FAIL nt_taken got %b exp 0", taken); end
    step();
    con_out = 1'b0;
    checks++; if (pc_out !== 32'h100) begin errors++; $display("[TB] FAIL nt_pc_hold got %h exp %h", pc_out, 32'h100); end
  endtask

  task automatic test_wrap();
    load_pc(32'h10);
    applyStimulus(19'h7FFF0, 1'b1);
    checks++; if (pc_out !== 32'h0) begin errors++; $display("[TB] FAIL neg_off got %h exp %h", pc_out, 32'h0); end
    load_pc(32'h2);
    applyStimulus(19'h7FFFE, 1'b1);
    checks++; if (pc_out !== 32'h0) begin errors++; $display("[TB] FAIL neg_off2 got %h exp %h", pc_out, 32'h0); end
    load_pc(32'hFFFF_FFFF);
    pc_inc_en = 1'b1;
    step();
    pc_inc_en = 1'b0;
    checks++; if (pc_out !== 32'h0) begin errors++; $display("[TB] FAIL inc_wrap got %h exp %h", pc_out, 32'h0); end
    load_pc(32'h0000_1000);
    applyStimulus(19'h3FFFF, 1'b1);
    checks++; if (pc_out !== 32'h0004_0FFF) begin errors++; $display("[TB] FAIL pos_max got %h exp %h", pc_out, 32'h0004_0FFF); end
  endtask

  task automatic test_ignore_busy();
    load_pc(32'h200);
    ir    = 32'h0000_0004;
    start = 1'b1;
    step();
    pc_inc_en   = 1'b1;
    pc_load_en  = 1'b1;
    pc_load_val = 32'h999;
    checks++; if (pc_out !== 32'h200) begin errors++; $display("[TB] FAIL busy_eval_pc got %h exp %h", pc_out, 32'h200); end
    step();
    con_out = 1'b1;
    checks++; if (pc_out !== 32'h200) begin errors++; $display("[TB] FAIL busy_res_pc got %h exp %h", pc_out, 32'h200); end
    step();
    con_out = 1'b0;
    checks++; if (pc_out !== 32'h204) begin errors++; $display("[TB] FAIL busy_done_pc got %h exp %h", pc_out, 32'h204); end
    step();
    start      = 1'b0;
    pc_inc_en  = 1'b0;
    pc_load_en = 1'b0;
    checks++; if ({pc_out, busy, con_in} !== {32'h204, 2'b00}) begin errors++; $display("[TB] FAIL busy_ignored got %h/%b%b exp 204/00", pc_out, busy, con_in); end
  endtask

  task automatic test_back_to_back();
    pc_load_val = 32'h300;
    pc_load_en  = 1'b1;
    pc_inc_en   = 1'b1;
    ir          = 32'h0000_0010;
    start       = 1'b1;
    step();
    pc_load_en = 1'b0;
    pc_inc_en  = 1'b0;
    start      = 1'b0;
    checks++; if ({pc_out, con_in} !== {32'h300, 1'b1}) begin errors++; $display("[TB] FAIL same_cycle_load got %h/%b exp 300/1", pc_out, con_in); end
    step();
    con_out = 1'b1;
    step();
    con_out = 1'b0;
    checks++; if (pc_out !== 32'h310) begin errors++; $display("[TB] FAIL load_then_add got %h exp %h", pc_out, 32'h310); end
    step();
    ir    = 32'h0007_FFFF;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if ({con_in, busy} !== 2'b11) begin errors++; $display("[TB] FAIL b2b_accept got %b exp 11", {con_in, busy}); end
    step();
    con_out = 1'b1;
    step();
    con_out = 1'b0;
    checks++; if ({pc_out, done} !== {32'h30F, 1'b1}) begin errors++; $display("[TB] FAIL b2b_pc got %h/%b exp 30f/1", pc_out, done); end
    step();
  endtask

  task automatic test_clr_mid_branch();
    load_pc(32'h500);
    ir    = 32'h0000_0020;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    con_out = 1'b1;
    clr     = 1'b1;
    step();
    clr     = 1'b0;
    con_out = 1'b0;
    checks++; if ({busy, done, con_in, taken} !== 4'b0000) begin errors++; $display("[TB] FAIL clr_mid_flags got %b exp 0000", {busy, done, con_in, taken}); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("[TB] FAIL clr_mid_pc got %h exp %h", pc_out, 32'h0); end
    step();
    checks++; if ({done, busy} !== 2'b00) begin errors++; $display("[TB] FAIL clr_no_done got %b exp 00", {done, busy}); end
  endtask

  task automatic test_stats();
    logic [1:0] exp_t, exp_nt;
`ifdef BRANCH_STATS_EN
    exp_t  = 2'd3;
    exp_nt = 2'd1;
`else
    exp_t  = 2'd0;
    exp_nt = 2'd0;
`endif
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(19'h1, 1'b1);
    applyStimulus(19'h1, 1'b0);
    checks++; if (taken_cnt !== exp_t) begin errors++; $display("[TB] FAIL taken_cnt got %0d exp %0d", taken_cnt, exp_t); end
    checks++; if (not_taken_cnt !== exp_nt) begin errors++; $display("[TB] FAIL not_taken_cnt got %0d exp %0d", not_taken_cnt, exp_nt); end
    checks++; if (pc_out !== 32'h5) begin errors++; $display("[TB] FAIL stats_pc got %h exp %h", pc_out, 32'h5); end
  endtask

  initial begin
    test_reset();
    test_increment();
    test_branch_taken();
    test_branch_not_taken();
    test_wrap();
    test_ignore_busy();
    test_back_to_back();
    test_clr_mid_branch();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
